// File: rtl/pb_pkg.sv
// Shared definitions for the push-button scan controller: scan FSM states,
// default timing constants and the channel-index width helper.
package pb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  localparam int DEF_TICK_DIV = 50000;
  localparam int DEF_HIST     = 8;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pb_tick_gen.sv
// Sample-tick prescaler: counts 0..TICK_DIV-1 while enabled and raises a
// one-cycle tick in the terminal-count cycle; disabling parks the count at 0.
module pb_tick_gen
  import pb_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!en || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pb_scan_ctrl.sv
// Shared-scan debouncer for N_BTN push buttons. The release pulse port is
// named release_evt because "release" is a reserved SystemVerilog keyword.
module pb_scan_ctrl
  import pb_pkg::*;
#(
  parameter int N_BTN    = 4,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int HIST     = DEF_HIST
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_BTN-1:0]   button,
  input  logic               force_scan,
  input  logic               ovr_clr,
  output logic [N_BTN-1:0]   btn_state,
  output logic [N_BTN-1:0]   press,
  output logic [N_BTN-1:0]   release_evt,
  output logic               busy,
  output logic               overrun,
  output scan_state_t        scan_state
);

  localparam int IDX_W = idx_width(N_BTN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BTN - 1);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [HIST-1:0]  hist [N_BTN];
  logic [HIST-1:0]  hist_new;
  logic [IDX_W-1:0] idx;
  logic             pending;
  logic             tick;
  logic             req;
  logic             ovr_set;
  scan_state_t      state_q;
  scan_state_t      state_d;

  pb_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // A tick and a forced scan landing together merge into one request.
  assign req     = tick | force_scan;
  assign ovr_set = (state_q == ST_SCAN) && req && pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req || pending) state_d = ST_SCAN;
      ST_SCAN: if (idx == LAST_IDX) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == ST_SCAN);
    scan_state = state_q;
  end

  // At most one request can wait behind a running scan; a second one is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (state_q == ST_SCAN) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        if (req && !pending) pending <= 1'b1;
      end else begin
        idx     <= '0;
        pending <= 1'b0;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign hist_new = {hist[idx][HIST-2:0], sync2[idx]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) hist[i] <= '0;
      btn_state   <= '0;
      press       <= '0;
      release_evt <= '0;
    end else begin
      press       <= '0;
      release_evt <= '0;
      if (state_q == ST_SCAN) begin
        hist[idx] <= hist_new;
        // Level only moves on a full run of agreeing samples.
        if ((&hist_new) && !btn_state[idx]) begin
          btn_state[idx] <= 1'b1;
          press[idx]     <= 1'b1;
        end else if (!(|hist_new) && btn_state[idx]) begin
          btn_state[idx]   <= 1'b0;
          release_evt[idx] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pb_scan_ctrl.sv
// Randomized bench for pb_scan_ctrl: a run-length debounce model predicts
// press/release events into a queue that a separate monitor consumes.
module tb_pb_scan_ctrl;
  import pb_pkg::*;

  localparam int N  = 4;
  localparam int TD = 10;
  localparam int H  = 4;
  localparam int EW = 32 + 2 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [N-1:0]  button = '0;
  logic          force_scan = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [N-1:0]  btn_state;
  logic [N-1:0]  press;
  logic [N-1:0]  release_evt;
  logic          busy;
  logic          overrun;
  scan_state_t   scan_state;

  int unsigned   chk_cnt = 0;
  int unsigned   pass_cnt = 0;
  int unsigned   cyc = 0;
  logic [EW-1:0] exp_q[$];

  pb_scan_ctrl #(
    .N_BTN    (N),
    .TICK_DIV (TD),
    .HIST     (H)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .button      (button),
    .force_scan  (force_scan),
    .ovr_clr     (ovr_clr),
    .btn_state   (btn_state),
    .press       (press),
    .release_evt (release_evt),
    .busy        (busy),
    .overrun     (overrun),
    .scan_state  (scan_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  int          m_cnt = 0;
  int          scan_pos = -1;
  bit          m_pending = 0;
  bit          m_ovr = 0;
  logic [N-1:0] m_state = '0;
  logic [N-1:0] m_s1 = '0;
  logic [N-1:0] m_s2 = '0;
  logic        run_val [N];
  int          run_len [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      run_val[i] = 1'b0;
      run_len[i] = H;
    end
  end

  always @(negedge clk) begin
    bit           tick_m;
    bit           req_m;
    bit           ovr_set;
    int           ch;
    logic         v;
    logic [N-1:0] pv;
    logic [N-1:0] rv;
    if (!rst_n) begin
      check("reset_busy", busy, 0);
      check("reset_state", btn_state, 0);
      check("reset_overrun", overrun, 0);
      check("reset_pulses", {press, release_evt}, 0);
      m_cnt = 0; scan_pos = -1; m_pending = 0; m_ovr = 0;
      m_state = '0; m_s1 = '0; m_s2 = '0;
      for (int i = 0; i < N; i++) begin
        run_val[i] = 1'b0;
        run_len[i] = H;
      end
      exp_q.delete();
    end else begin
      check("busy", busy, (scan_pos >= 0));
      check("btn_state", btn_state, m_state);
      check("overrun", overrun, m_ovr);
      tick_m  = en && (m_cnt == TD - 1);
      req_m   = tick_m || force_scan;
      ovr_set = 0;
      if (scan_pos >= 0) begin
        ch = scan_pos;
        v  = m_s2[ch];
        if (v == run_val[ch]) run_len[ch]++;
        else begin
          run_val[ch] = v;
          run_len[ch] = 1;
        end
        pv = '0; rv = '0;
        if (run_len[ch] >= H && run_val[ch] && !m_state[ch]) begin
          m_state[ch] = 1'b1; pv[ch] = 1'b1;
        end else if (run_len[ch] >= H && !run_val[ch] && m_state[ch]) begin
          m_state[ch] = 1'b0; rv[ch] = 1'b1;
        end
        if (pv != 0 || rv != 0) exp_q.push_back({32'(cyc + 1), pv, rv});
        if (req_m) begin
          if (m_pending) ovr_set = 1;
          else m_pending = 1;
        end
        scan_pos = (scan_pos == N - 1) ? -1 : scan_pos + 1;
      end else if (req_m || m_pending) begin
        scan_pos  = 0;
        m_pending = 0;
      end
      if (ovr_set) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
      m_cnt = (!en || tick_m) ? 0 : m_cnt + 1;
      m_s2  = m_s1;
      m_s1  = button;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [31:0]   ecyc;
    if (rst_n) begin
      while (exp_q.size() > 0) begin
        e    = exp_q[0];
        ecyc = e[EW-1 -: 32];
        if (ecyc >= cyc) break;
        check("event_missed", cyc, ecyc);
        void'(exp_q.pop_front());
      end
      if ((press | release_evt) != 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {press, release_evt}, 0);
        end else begin
          e    = exp_q.pop_front();
          ecyc = e[EW-1 -: 32];
          check("event_cycle", cyc, ecyc);
          check("event_press", press, e[2*N-1:N]);
          check("event_release", release_evt, e[N-1:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_force(input bit with_clr);
    force_scan = 1'b1;
    ovr_clr    = with_clr;
    step(1);
    force_scan = 1'b0;
    ovr_clr    = 1'b0;
  endtask

  // Leaves the bench in the first cycle of a scan (channel 0).
  task automatic wait_scan_start();
    int k = 0;
    while (busy && k < 50) begin step(1); k++; end
    while (!busy && k < 100) begin step(1); k++; end
    if (!busy) check("scan_start_timeout", 0, 1);
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    en    = 1'b1;
    step(30);

    button[2] = 1'b1;
    step(60);
    check("press2_level", btn_state, 4'b0100);

    for (int i = 0; i < 20; i++) begin
      button[0] = ~button[0];
      step(5);
    end
    button[0] = 1'b0;
    step(50);

    button = '1;
    step(50);
    check("all_pressed", btn_state, 4'b1111);
    button = '0;
    step(50);
    check("all_released", btn_state, 4'b0000);

    wait_scan_start();
    pulse_force(1'b0);
    pulse_force(1'b0);
    step(3);
    check("overrun_set", overrun, 1);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    check("overrun_clr", overrun, 0);
    step(12);
    wait_scan_start();
    pulse_force(1'b0);
    pulse_force(1'b0);
    step(12);
    wait_scan_start();
    pulse_force(1'b0);
    pulse_force(1'b1);
    step(1);
    check("overrun_set_wins", overrun, 1);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    step(20);

    for (int c = 0; c < 1500; c++) begin
      en         = ($urandom_range(0, 19) != 0);
      force_scan = ($urandom_range(0, 14) == 0);
      ovr_clr    = ($urandom_range(0, 29) == 0);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 39) == 0) button[b] = ~button[b];
      step(1);
    end
    force_scan = 1'b0;
    ovr_clr    = 1'b0;
    en         = 1'b1;

    button = '1;
    step(60);
    check("pre_reset_state", btn_state, 4'b1111);
    wait_scan_start();
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_state", btn_state, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_pulses", {press, release_evt}, 0);
    step(3);
    rst_n = 1'b1;
    step(60);
    check("post_reset_state", btn_state, 4'b1111);

    step(10);
    check("leftover_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pb_scan_ctrl.md
Name: pb_scan_ctrl

Overview:
Debounce scheduler for the push-button inputs on the board.
- One shared sample-tick prescaler and one scan FSM sequence the debounce of N_BTN buttons.
- Each channel keeps an HIST-bit shift history and a debounced level.
- Emits single-cycle press/release event pulses to downstream control logic.
- Replaces per-button debouncers, each with its own divider, and adds a manual scan request with pending/overrun tracking.

Parameters:
N_BTN, 4, number of button channels (1..16)
TICK_DIV, 50000, clk cycles per sample tick (1 ms at 50 MHz); must be >= 2
HIST, 8, debounce history length in samples (2..16)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  prescaler enable; 0 holds prescaler count at 0
button  in  N_BTN  raw asynchronous button inputs
force_scan  in  1  1-cycle request for an immediate extra scan
ovr_clr  in  1  clears sticky overrun
btn_state  out  N_BTN  debounced levels
press  out  N_BTN  1-cycle pulse on debounced 0->1
release  out  N_BTN  1-cycle pulse on debounced 1->0
busy  out  1  high while FSM is in SCAN
overrun  out  1  sticky: scan request lost

Behaviour:
Reset (async assert, sync deassert via clk edge):
- prescaler=0, idx=0, FSM=IDLE, pending=0.
- All histories=0, btn_state=0, press=0, release=0, busy=0, overrun=0.

Input synchroniser:
- 2-flop on each button bit; the scan samples sync[i] (2-cycle latency from pin).

Prescaler:
- While en=1, counts 0..TICK_DIV-1. tick is high in the cycle count==TICK_DIV-1, and count wraps to 0 on that cycle.
- en=0: count forced to 0, no tick. A scan already in progress completes.

Scan request:
- req = tick | force_scan.

FSM IDLE:
- req or pending -> SCAN with idx=0; pending cleared.

FSM SCAN:
- One channel per cycle at index idx. On the clock edge:
  - hist[idx] <= {hist[idx][HIST-2:0], sync[idx]}.
  - new==all-ones and btn_state[idx]==0 -> btn_state[idx]<=1, press[idx]<=1.
  - new==all-zeros and btn_state[idx]==1 -> btn_state[idx]<=0, release[idx]<=1.
  - Otherwise btn_state[idx] holds (hysteresis).
- idx==N_BTN-1 -> IDLE, idx<=0; else idx<=idx+1.
- busy=1 exactly during SCAN, i.e. N_BTN cycles per scan.

Latency:
- tick in cycle T -> channel i updated at the edge ending cycle T+1+i.
- press/release for channel i is visible in cycle T+2+i.

Pulses:
- press and release are registered and cleared every cycle unless re-set, so each lasts exactly 1 cycle.

Collisions:
- req during SCAN: pending<=1.
- req while pending already 1 and FSM in SCAN: overrun<=1 (sticky); the request is dropped.
- req in IDLE while pending=1 (simultaneous): one scan only, no overrun.
- tick and force_scan in the same cycle count as one request.

overrun:
- Cleared by ovr_clr. If ovr_clr and a new overrun event occur in the same cycle, set wins.

Reset mid-scan:
- Everything returns to reset values immediately. No pulses are emitted during reset.

Constraint:
- TICK_DIV > N_BTN guarantees tick alone never causes overrun.

Decomposition:
- Shared package pb_pkg:
  - FSM state enum (ST_IDLE, ST_SCAN).
  - Index width function clog2(N_BTN).
  - Default TICK_DIV/HIST constants.
- One natural sub-module: pb_tick_gen (prescaler with en, outputs 1-cycle tick). Scan FSM, histories and synchronisers stay in pb_scan_ctrl.

Test Plan:
Bench parameters: N_BTN=4, TICK_DIV=10, HIST=4.
- Reset release, en=1, button=0 -> tick every 10 cycles; busy high 4 cycles after each tick; no press/release; btn_state=0.
- button[2] held 1 -> press[2] single pulse in cycle T+4 of the 4th tick after the synced rise; btn_state=4'b0100; no other pulses.
- button[0] toggles 1/0 every 5 cycles (bounce) for 100 cycles, then stable 0 -> no press[0]/release[0]; btn_state[0]=0 throughout.
- All buttons 1 for 4 ticks, then all 0 for 4 ticks -> press[0..3] in consecutive cycles T+2..T+5; later release[0..3] likewise; each pulse width 1.
- force_scan during busy -> one extra scan immediately after the current one; a second force_scan while pending -> overrun=1. ovr_clr -> overrun=0. A simultaneous force_scan (new overrun event) and ovr_clr -> overrun stays 1.
- Assert rst_n=0 mid-scan (idx=2) with btn_state=4'b1111 -> all outputs 0 asynchronously. After release, the first press requires 4 fresh all-ones samples.
